tlc_phase_sequencer: RTL and testbench
======================================

# tlc_phase_sequencer

Parametrised, self-timing traffic light controller for a junction of NUM_DIR approaches. It replaces externally driven per-approach light codes with an internal phase FSM:
- round-robin service of approaches that have a latched vehicle request;
- programmable turn-arrow, green, yellow and all-red durations.

It drives the straight-ahead and turn-arrow lamp drivers directly and sits between the vehicle detectors and the lamp outputs.

## Interface
- NUM_DIR, 4, number of approaches (2..8)
- DIR_W, 2, width of approach index; must be at least clog2(NUM_DIR)
- CNT_W, 8, width of the phase timer
- TURN_CYC, 2, cycles of straight+turn green (1..2^CNT_W)
- GREEN_CYC, 4, cycles of straight-only green (1..2^CNT_W)
- YELLOW_CYC, 2, cycles of yellow (1..2^CNT_W)
- ALLRED_CYC, 1, cycles of all-red clearance (1..2^CNT_W)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  advance enable; low freezes FSM, timer and lights
- req  in  NUM_DIR  vehicle detector per approach; a single-cycle pulse is sufficient
- st_light  out  2*NUM_DIR  straight lamp per approach, bits [2i+1:2i]: 00 red, 01 green, 10 yellow, 11 never driven
- turn_green  out  NUM_DIR  turn arrow per approach: 1 green, 0 red
- active_dir  out  DIR_W  approach currently or most recently served
- busy  out  1  high in any state except IDLE
- pending  out  NUM_DIR  latched, not-yet-served requests

## Operation
- States:
  - IDLE: all red.
  - TURN: active approach straight green + arrow.
  - GREEN: straight green, arrow red.
  - YELLOW.
  - ALLRED: all red.
- Request latch:
  - pending[i] is set on the rising edge of clk when en=1 and req[i]=1.
  - pending[i] is cleared on the cycle approach i enters TURN.
  - Set and clear in the same cycle: set wins, so the approach is re-queued.
- Selection:
  - From IDLE or at the end of ALLRED, the next approach is the first i with pending[i]=1.
  - The search starts at active_dir+1 and wraps modulo NUM_DIR, so active_dir itself is checked last.
  - No pending request: go to, or stay in, IDLE.
- Transitions (en=1):
  - IDLE -> TURN when any pending bit is set.
  - TURN -> GREEN -> YELLOW -> ALLRED, each after its programmed cycle count.
  - ALLRED -> TURN on the selected approach, or -> IDLE if nothing is pending.
- Timer:
  - Loaded with duration-1 on state entry and decremented while en=1.
  - The state exits on the cycle the timer reads 0, so each state lasts exactly its parameter in enabled cycles.
- Outputs:
  - Only active_dir shows non-red lamps.
  - Two approaches are never green or yellow together.
  - turn_green is high only in TURN.
- Reset:
  - Asynchronous; takes effect immediately, including mid-phase.
  - Reset values: state IDLE, st_light all 00, turn_green 0, active_dir NUM_DIR-1 (so that approach 0 is searched first), busy 0, pending 0, timer 0.

## Timing
- All outputs are registered and change only on rising edges (or asynchronously to reset values).
- Latency: req pulse at edge k in IDLE -> pending set at k -> TURN entered and lamps green at edge k+1.
- Full cycle per served approach = TURN_CYC+GREEN_CYC+YELLOW_CYC+ALLRED_CYC enabled cycles; 9 with the default parameters.
- en=0: state, timer, lamps and pending all hold, and req is ignored.
- Back-to-back service: ALLRED's last cycle is followed directly by TURN of the next approach, with no IDLE cycle in between.

## Configuration
- TLC_EMERGENCY_EN defined: adds input emg (1 bit) and input emg_dir (DIR_W bits), plus state EMG.
  - emg=1 in TURN or GREEN: forces YELLOW next cycle (timer reloaded), then ALLRED.
  - From ALLRED or IDLE, emg=1 enters EMG, with active_dir set to emg_dir and straight green only.
  - EMG holds while emg=1; on deassertion: YELLOW -> ALLRED -> normal selection.
  - pending is preserved throughout.
- Undefined: no emg ports, no EMG state; behaviour is exactly as above.

## Test plan
- Reset/idle: rst=0 for 3 cycles, then release with req=0 -> st_light=0x00, turn_green=0, busy=0, active_dir=3 for 20 cycles.
- Single request: req=0001 pulse -> approach 0:
  - TURN for 2 cycles: st_light[1:0]=01, turn_green=0001;
  - GREEN for 4 cycles: turn_green=0;
  - YELLOW for 2 cycles: 10;
  - ALLRED for 1 cycle;
  - then IDLE, busy=0.
- Round-robin: req=1011 pulse while idle -> served order 0,1,3 with no IDLE between phases; 27 cycles total, then idle.
- Re-request and wrap: req[3] held high throughout service of approach 3 -> pending[3] re-set; approach 3 served again after the search wraps through 0..2.
- Freeze: en=0 for 5 cycles mid-GREEN -> lamps and timer unchanged; GREEN then completes its remaining cycles after en=1.
- Reset mid-operation: rst=0 during YELLOW of approach 2 -> all lamps red and pending=0 immediately, without waiting for a clock edge.
- With TLC_EMERGENCY_EN, emg=1 and emg_dir=2 asserted during GREEN of approach 0:
  - YELLOW 2 cycles, ALLRED 1 cycle, then approach 2 st_light=01 with turn_green=0 for as long as emg=1;
  - pending from before the event is unchanged.

Source files
------------

// File: rtl/tlc_phase_sequencer_if.sv
// Detector/lamp bundle for tlc_phase_sequencer; the emg/emg_dir members exist only
// when TLC_EMERGENCY_EN is defined.
interface tlc_phase_sequencer_if #(
  parameter int NUM_DIR = 4,
  parameter int DIR_W   = 2
);
  logic                   en;
  logic [NUM_DIR-1:0]     req;
  logic [2*NUM_DIR-1:0]   st_light;
  logic [NUM_DIR-1:0]     turn_green;
  logic [DIR_W-1:0]       active_dir;
  logic                   busy;
  logic [NUM_DIR-1:0]     pending;
`ifdef TLC_EMERGENCY_EN
  logic                   emg;
  logic [DIR_W-1:0]       emg_dir;

  modport master (
    output en, req, emg, emg_dir,
    input  st_light, turn_green, active_dir, busy, pending
  );
  modport slave (
    input  en, req, emg, emg_dir,
    output st_light, turn_green, active_dir, busy, pending
  );
`else
  modport master (
    output en, req,
    input  st_light, turn_green, active_dir, busy, pending
  );
  modport slave (
    input  en, req,
    output st_light, turn_green, active_dir, busy, pending
  );
`endif
endinterface

// File: rtl/tlc_phase_sequencer.sv
// Self-timing round-robin traffic light phase sequencer (TURN/GREEN/YELLOW/ALLRED).
// Optional emergency override is enabled by defining TLC_EMERGENCY_EN.
module tlc_phase_sequencer #(
  parameter int NUM_DIR    = 4,
  parameter int DIR_W      = 2,
  parameter int CNT_W      = 8,
  parameter int TURN_CYC   = 2,
  parameter int GREEN_CYC  = 4,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1
) (
  input logic                  clk,
  input logic                  rst,
  tlc_phase_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       LAMP_GRN  = 2'b01;
  localparam logic [1:0]       LAMP_YEL  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TURN   = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_ALLRED = 3'd4
`ifdef TLC_EMERGENCY_EN
    , S_EMG  = 3'd5
`endif
  } state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     timer_r;
  logic [DIR_W-1:0]     active_dir_r;
  logic [NUM_DIR-1:0]   pending_r;
  logic [2*NUM_DIR-1:0] st_light_r;
  logic [NUM_DIR-1:0]   turn_green_r;
  logic                 busy_r;

  logic                 sel_found_s;
  logic [DIR_W-1:0]     sel_dir_s;
  logic                 decide_s;
  logic                 emg_s;
  logic                 emg_go_s;
  logic                 turn_go_s;
  logic [NUM_DIR-1:0]   pending_next_s;

  function automatic logic [2*NUM_DIR-1:0] lamp_f(input logic [DIR_W-1:0] dir,
                                                  input logic [1:0] code);
    logic [2*NUM_DIR-1:0] v;
    v = {(2*NUM_DIR){1'b0}};
    for (int i = 0; i < NUM_DIR; i++) begin
      v[2*i +: 2] = (DIR_W'(i) == dir) ? code : 2'b00;
    end
    return v;
  endfunction

  function automatic logic [NUM_DIR-1:0] onehot_f(input logic [DIR_W-1:0] dir);
    logic [NUM_DIR-1:0] v;
    v = {NUM_DIR{1'b0}};
    for (int i = 0; i < NUM_DIR; i++) begin
      v[i] = (DIR_W'(i) == dir);
    end
    return v;
  endfunction

`ifdef TLC_EMERGENCY_EN
  assign emg_s = bus.emg;
`else
  assign emg_s = 1'b0;
`endif

  // Round-robin pick: nearest pending approach after active_dir; descending k lets the closest win.
  always_comb begin
    sel_found_s = 1'b0;
    sel_dir_s   = active_dir_r;
    for (int k = NUM_DIR; k >= 1; k--) begin
      for (int i = 0; i < NUM_DIR; i++) begin
        if (pending_r[i] && (((int'(active_dir_r) + k) % NUM_DIR) == i)) begin
          sel_dir_s   = DIR_W'(i);
          sel_found_s = 1'b1;
        end else begin
          sel_found_s = sel_found_s;
        end
      end
    end
  end

  // Decision points and next request latch (set wins over the clear on TURN entry).
  always_comb begin
    decide_s       = (state_r == S_IDLE) || ((state_r == S_ALLRED) && (timer_r == CNT_ZERO));
    emg_go_s       = decide_s && emg_s;
    turn_go_s      = decide_s && !emg_s && sel_found_s;
    pending_next_s = (pending_r & ~(turn_go_s ? onehot_f(sel_dir_s) : {NUM_DIR{1'b0}})) | bus.req;
  end

  // Phase FSM with timer, request latch and registered lamp outputs; en=0 holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      timer_r      <= CNT_ZERO;
      active_dir_r <= DIR_W'(NUM_DIR - 1);
      pending_r    <= {NUM_DIR{1'b0}};
      st_light_r   <= {(2*NUM_DIR){1'b0}};
      turn_green_r <= {NUM_DIR{1'b0}};
      busy_r       <= 1'b0;
    end else if (bus.en) begin
      pending_r <= pending_next_s;
`ifdef TLC_EMERGENCY_EN
      if (emg_go_s) begin
        state_r      <= S_EMG;
        timer_r      <= CNT_ZERO;
        active_dir_r <= bus.emg_dir;
        st_light_r   <= lamp_f(bus.emg_dir, LAMP_GRN);
        turn_green_r <= {NUM_DIR{1'b0}};
        busy_r       <= 1'b1;
      end else
`endif
      if (turn_go_s) begin
        state_r      <= S_TURN;
        timer_r      <= TURN_LD;
        active_dir_r <= sel_dir_s;
        st_light_r   <= lamp_f(sel_dir_s, LAMP_GRN);
        turn_green_r <= onehot_f(sel_dir_s);
        busy_r       <= 1'b1;
      end else begin
        case (state_r)
          S_IDLE: begin
            state_r <= S_IDLE;
          end
          S_TURN: begin
            if (emg_s) begin
              state_r      <= S_YELLOW;
              timer_r      <= YELLOW_LD;
              st_light_r   <= lamp_f(active_dir_r, LAMP_YEL);
              turn_green_r <= {NUM_DIR{1'b0}};
            end else if (timer_r == CNT_ZERO) begin
              state_r      <= S_GREEN;
              timer_r      <= GREEN_LD;
              turn_green_r <= {NUM_DIR{1'b0}};
            end else begin
              timer_r <= timer_r - CNT_ONE;
            end
          end
          S_GREEN: begin
            if (emg_s || (timer_r == CNT_ZERO)) begin
              state_r    <= S_YELLOW;
              timer_r    <= YELLOW_LD;
              st_light_r <= lamp_f(active_dir_r, LAMP_YEL);
            end else begin
              timer_r <= timer_r - CNT_ONE;
            end
          end
          S_YELLOW: begin
            if (timer_r == CNT_ZERO) begin
              state_r    <= S_ALLRED;
              timer_r    <= ALLRED_LD;
              st_light_r <= {(2*NUM_DIR){1'b0}};
            end else begin
              timer_r <= timer_r - CNT_ONE;
            end
          end
          S_ALLRED: begin
            if (timer_r == CNT_ZERO) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else begin
              timer_r <= timer_r - CNT_ONE;
            end
          end
`ifdef TLC_EMERGENCY_EN
          S_EMG: begin
            if (emg_s) begin
              state_r <= S_EMG;
            end else begin
              state_r    <= S_YELLOW;
              timer_r    <= YELLOW_LD;
              st_light_r <= lamp_f(active_dir_r, LAMP_YEL);
            end
          end
`endif
          default: begin
            state_r      <= S_IDLE;
            timer_r      <= CNT_ZERO;
            st_light_r   <= {(2*NUM_DIR){1'b0}};
            turn_green_r <= {NUM_DIR{1'b0}};
            busy_r       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.st_light   = st_light_r;
  assign bus.turn_green = turn_green_r;
  assign bus.active_dir = active_dir_r;
  assign bus.busy       = busy_r;
  assign bus.pending    = pending_r;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Directed bench for tlc_phase_sequencer with default parameters (4 approaches, 2/4/2/1 cycles).
module tb_tlc_phase_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  tlc_phase_sequencer_if #(.NUM_DIR(4), .DIR_W(2)) bus ();

  tlc_phase_sequencer #(
    .NUM_DIR(4), .DIR_W(2), .CNT_W(8),
    .TURN_CYC(2), .GREEN_CYC(4), .YELLOW_CYC(2), .ALLRED_CYC(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] green_l(input int d);
    logic [7:0] one;
    one = 8'h01;
    return one << (2*d);
  endfunction

  function automatic logic [7:0] yellow_l(input int d);
    logic [7:0] two;
    two = 8'h02;
    return two << (2*d);
  endfunction

  function automatic logic [31:0] observe();
    return {13'd0, bus.st_light, bus.turn_green, bus.active_dir, bus.busy, bus.pending};
  endfunction

  // Check {lamps, arrows, active_dir, busy, pending} on n consecutive falling edges.
  task automatic phase(input string tag, input int n, input logic [7:0] st, input logic [3:0] tg,
                       input logic [1:0] ad, input logic bsy, input logic [3:0] pd);
    for (int c = 0; c < n; c++) begin
      check_eq($sformatf("%s[%0d]", tag, c), observe(), {13'd0, st, tg, ad, bsy, pd});
      @(negedge clk);
    end
  endtask

  // One full service of approach d; rq is driven onto req during its ALLRED cycle.
  task automatic serve(input int d, input logic [3:0] pd, input logic [3:0] rq);
    logic [3:0] arrow;
    arrow = 4'b0001 << d;
    phase($sformatf("turn%0d", d),   2, green_l(d),  arrow, 2'(d), 1'b1, pd);
    phase($sformatf("green%0d", d),  4, green_l(d),  4'h0,  2'(d), 1'b1, pd);
    phase($sformatf("yellow%0d", d), 2, yellow_l(d), 4'h0,  2'(d), 1'b1, pd);
    bus.req = rq;
    phase($sformatf("allred%0d", d), 1, 8'h00,       4'h0,  2'(d), 1'b1, pd);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    bus.en   = 1'b1;
    bus.req  = 4'h0;
`ifdef TLC_EMERGENCY_EN
    bus.emg     = 1'b0;
    bus.emg_dir = 2'd0;
`endif
    repeat (3) @(negedge clk);
    phase("in_reset", 1, 8'h00, 4'h0, 2'd3, 1'b0, 4'h0);
    rst = 1'b1;
    phase("idle", 20, 8'h00, 4'h0, 2'd3, 1'b0, 4'h0);

    // Round-robin from reset: 0, 1, 3 back-to-back.
    bus.req = 4'b1011;
    @(negedge clk);
    bus.req = 4'h0;
    phase("rr_wait", 1, 8'h00, 4'h0, 2'd3, 1'b0, 4'b1011);
    serve(0, 4'b1010, 4'h0);
    serve(1, 4'b1000, 4'h0);
    serve(3, 4'b0000, 4'h0);
    phase("rr_idle", 3, 8'h00, 4'h0, 2'd3, 1'b0, 4'h0);

    // Single request.
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = 4'h0;
    phase("sr_wait", 1, 8'h00, 4'h0, 2'd3, 1'b0, 4'b0001);
    serve(0, 4'b0000, 4'h0);
    phase("sr_idle", 2, 8'h00, 4'h0, 2'd0, 1'b0, 4'h0);

    // req[3] held through approach 3's service re-queues it; served again after wrap.
    bus.req = 4'b1100;
    @(negedge clk);
    bus.req = 4'h0;
    phase("rq_wait", 1, 8'h00, 4'h0, 2'd0, 1'b0, 4'b1100);
    serve(2, 4'b1000, 4'b1000);
    serve(3, 4'b1000, 4'b0000);
    serve(3, 4'b0000, 4'h0);
    phase("rq_idle", 2, 8'h00, 4'h0, 2'd3, 1'b0, 4'h0);

    // Freeze mid-GREEN; req during freeze is ignored.
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = 4'h0;
    phase("fz_wait",   1, 8'h00,      4'h0,    2'd3, 1'b0, 4'b0010);
    phase("fz_turn",   2, green_l(1), 4'b0010, 2'd1, 1'b1, 4'h0);
    phase("fz_green",  2, green_l(1), 4'h0,    2'd1, 1'b1, 4'h0);
    bus.en  = 1'b0;
    bus.req = 4'b0001;
    phase("fz_hold",   5, green_l(1), 4'h0,    2'd1, 1'b1, 4'h0);
    bus.req = 4'h0;
    bus.en  = 1'b1;
    phase("fz_green2", 2, green_l(1),  4'h0,   2'd1, 1'b1, 4'h0);
    phase("fz_yel",    2, yellow_l(1), 4'h0,   2'd1, 1'b1, 4'h0);
    phase("fz_ar",     1, 8'h00,       4'h0,   2'd1, 1'b1, 4'h0);
    phase("fz_idle",   2, 8'h00,       4'h0,   2'd1, 1'b0, 4'h0);

    // Asynchronous reset during YELLOW of approach 2 with a request pending.
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = 4'h0;
    phase("mr_wait",  1, 8'h00,      4'h0,    2'd1, 1'b0, 4'b0100);
    phase("mr_turn",  2, green_l(2), 4'b0100, 2'd2, 1'b1, 4'h0);
    bus.req = 4'b0001;
    phase("mr_green", 1, green_l(2), 4'h0,    2'd2, 1'b1, 4'h0);
    bus.req = 4'h0;
    phase("mr_green", 3, green_l(2),  4'h0,   2'd2, 1'b1, 4'b0001);
    phase("mr_yel",   1, yellow_l(2), 4'h0,   2'd2, 1'b1, 4'b0001);
    rst = 1'b0;
    #1;
    check_eq("mr_async", observe(), {13'd0, 8'h00, 4'h0, 2'd3, 1'b0, 4'h0});
    @(negedge clk);
    rst = 1'b1;
    phase("mr_idle", 3, 8'h00, 4'h0, 2'd3, 1'b0, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
